// File: rtl/vec_div_pkg.sv
// Shared encodings and lane helpers for the iterative packed-lane divider.
//   precision : 00 = 4x8-bit, 01 = 2x16-bit, 10/11 = 1x32-bit
//   op_sel    : 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU (bit0 = unsigned, bit1 = remainder)
//   FSM states: IDLE, PREP, ITER, FIX, DONE
package vec_div_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [1:0] PREC_8    = 2'b00;
    localparam logic [1:0] PREC_16   = 2'b01;
    localparam logic [1:0] PREC_32   = 2'b10;
    localparam logic [1:0] PREC_RSVD = 2'b11;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Copy the flag held at each lane's top byte to every byte of that lane.
    function automatic logic [3:0] lane_bcast(input logic [3:0] top, input logic [1:0] prec);
        case (prec)
            PREC_8:  return top;
            PREC_16: return {top[3], top[3], top[1], top[1]};
            default: return {4{top[3]}};
        endcase
    endfunction

    // AND per-byte flags across each lane, result broadcast per byte.
    function automatic logic [3:0] lane_and(input logic [3:0] f, input logic [1:0] prec);
        case (prec)
            PREC_8:  return f;
            PREC_16: return {{2{f[3] & f[2]}}, {2{f[1] & f[0]}}};
            default: return {4{&f}};
        endcase
    endfunction

    // Bytes that hold the least-significant bits of a lane.
    function automatic logic [3:0] lane_start(input logic [1:0] prec);
        case (prec)
            PREC_8:  return 4'b1111;
            PREC_16: return 4'b0101;
            default: return 4'b0001;
        endcase
    endfunction

    // Lane width, which is also the number of restoring iterations.
    function automatic logic [CNT_W-1:0] lane_bits(input logic [1:0] prec);
        case (prec)
            PREC_8:  return CNT_W'(8);
            PREC_16: return CNT_W'(16);
            default: return CNT_W'(32);
        endcase
    endfunction

    // Two's-complement negate every lane independently.
    function automatic logic [DATA_W-1:0] lane_neg(input logic [DATA_W-1:0] x, input logic [1:0] prec);
        logic [DATA_W-1:0] r;
        case (prec)
            PREC_8: begin
                for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'd0 - x[i*8 +: 8];
            end
            PREC_16: begin
                r[15:0]  = 16'd0 - x[15:0];
                r[31:16] = 16'd0 - x[31:16];
            end
            default: r = 32'd0 - x;
        endcase
        return r;
    endfunction

    // Per-byte select: sel ? a : b.
    function automatic logic [DATA_W-1:0] byte_mux(input logic [3:0] sel, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sel[i] ? a[i*8 +: 8] : b[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/div_lane_step.sv
// One 8-bit slice of a restoring-division trial subtract; slices chain through borrow.
//   a, b       : partial remainder and divisor bytes
//   borrow_in  : borrow from the next-lower slice (0 at a lane boundary)
//   diff       : a - b - borrow_in
//   borrow_out : borrow into the next-higher slice
module div_lane_step (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       borrow_in,
    output logic [7:0] diff,
    output logic       borrow_out
);

    assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {8'd0, borrow_in};

endmodule

// File: rtl/vector_divider_iterative.sv
// Iterative radix-2 restoring divider over packed 8/16/32-bit lanes, signed or unsigned,
// returning quotient or remainder per lane.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operation handshake (in_ready only in IDLE)
//   operand_a, operand_b : packed dividends / divisors
//   precision, op_sel    : lane width and operation
//   out_valid / out_ready: result handshake
//   result               : packed per-lane result, held outside DONE
//   busy                 : FSM not in IDLE
module vector_divider_iterative
    import vec_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [1:0]  precision,
    input  logic [1:0]  op_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        prec_r;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] quo;        // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] rem;        // partial remainder
    logic [DATA_W-1:0] div;        // divisor magnitude
    logic [3:0]        rem_sign;   // per-byte: negate remainder in FIX
    logic [3:0]        quo_sign;   // per-byte: negate quotient in FIX
    logic [3:0]        div_zero;   // per-byte: lane divisor is zero

    logic [3:0]        start;
    logic [3:0]        a_neg, b_neg, b_zero, qmsb, ge, bo;
    logic [DATA_W-1:0] rem_sh, diff, rem_nx, quo_nx;
    logic [DATA_W-1:0] q_fix, r_fix, fix_val;

    assign start  = lane_start(prec_r);
    assign a_neg  = lane_bcast({quo[31], quo[23], quo[15], quo[7]}, prec_r) & {4{~op_r[0]}};
    assign b_neg  = lane_bcast({div[31], div[23], div[15], div[7]}, prec_r) & {4{~op_r[0]}};
    assign b_zero = lane_and({div[31:24] == 8'd0, div[23:16] == 8'd0,
                              div[15:8] == 8'd0, div[7:0] == 8'd0}, prec_r);
    assign qmsb   = lane_bcast({quo[31], quo[23], quo[15], quo[7]}, prec_r);

    // Shift each lane's partial remainder left, pulling in that lane's next dividend bit.
    always_comb begin
        rem_sh[7:0] = {rem[6:0], qmsb[0]};
        for (int i = 1; i < 4; i++) begin
            rem_sh[i*8 +: 8] = {rem[i*8 +: 7], start[i] ? qmsb[i] : rem[i*8-1]};
        end
    end

    // Trial subtract slices; the borrow chain is cut at every lane boundary.
    for (genvar g = 0; g < 4; g++) begin : g_slice
        logic bin, bout;
        if (g == 0) begin : g_lsb
            assign bin = 1'b0;
        end else begin : g_chain
            assign bin = start[g] ? 1'b0 : g_slice[g-1].bout;
        end
        div_lane_step u_step (
            .a          (rem_sh[g*8 +: 8]),
            .b          (div[g*8 +: 8]),
            .borrow_in  (bin),
            .diff       (diff[g*8 +: 8]),
            .borrow_out (bout)
        );
        assign bo[g] = bout;
    end

    // Lane fits when the bit shifted out of the remainder was set or no borrow left the lane.
    assign ge = lane_bcast({rem[31], rem[23], rem[15], rem[7]} | ~bo, prec_r);

    always_comb begin
        quo_nx[7:0] = {quo[6:0], ge[0]};
        for (int i = 1; i < 4; i++) begin
            quo_nx[i*8 +: 8] = {quo[i*8 +: 7], start[i] ? ge[i] : quo[i*8-1]};
        end
        rem_nx = byte_mux(ge, diff, rem_sh);
    end

    // Sign correction and quotient/remainder selection.
    assign q_fix   = byte_mux(div_zero, 32'hFFFF_FFFF,
                              byte_mux(quo_sign, lane_neg(quo, prec_r), quo));
    assign r_fix   = byte_mux(rem_sign, lane_neg(rem, prec_r), rem);
    assign fix_val = op_r[1] ? r_fix : q_fix;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid) state_nx = ST_PREP;
            ST_PREP: state_nx = ST_ITER;
            ST_ITER: if (cnt == '0) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nx == ST_IDLE);
            busy      <= (state_nx != ST_IDLE);
            out_valid <= (state_nx == ST_DONE);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            prec_r   <= '0;
            op_r     <= '0;
            quo      <= '0;
            rem      <= '0;
            div      <= '0;
            rem_sign <= '0;
            quo_sign <= '0;
            div_zero <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        quo    <= operand_a;
                        div    <= operand_b;
                        prec_r <= (precision == PREC_RSVD) ? PREC_32 : precision;
                        op_r   <= op_sel;
                    end
                end
                ST_PREP: begin
                    quo      <= byte_mux(a_neg, lane_neg(quo, prec_r), quo);
                    div      <= byte_mux(b_neg, lane_neg(div, prec_r), div);
                    rem      <= '0;
                    cnt      <= lane_bits(prec_r);
                    rem_sign <= a_neg;
                    quo_sign <= a_neg ^ b_neg;
                    div_zero <= b_zero;
                end
                ST_ITER: begin
                    if (cnt != '0) begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX:  result <= fix_val;
                default: ;
            endcase
        end
    end

endmodule
